idr_reg: RTL and testbench

IDR_REG -- requirements
Module: idr_reg

---
 rtl/idr_reg_pkg.sv | 16 +
 rtl/idr_reg_word.sv | 23 ++
 rtl/idr_reg.sv | 62 ++++++
 tb/tb_idr_reg.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/idr_reg_pkg.sv
// Shared widths for the IDR register pair and the blocks that consume it.
// DW is the data word width; the double word carries {hi, lo}.
package idr_reg_pkg;

    localparam int IDR_DW  = 9;
    localparam int IDR_DW2 = 2 * IDR_DW;

    typedef logic [IDR_DW-1:0]  idr_word_t;
    typedef logic [IDR_DW2-1:0] idr_dword_t;

    // Builds the double word the way dout1 presents it: hi in the upper half.
    function automatic idr_dword_t idr_pack(input idr_word_t hi, input idr_word_t lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/idr_reg_word.sv
// W-bit enable register with asynchronous active-low clear.
// Used for every storage and output word of idr_reg.
module idr_word
    import idr_reg_pkg::*;
#(
    parameter int W = IDR_DW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/idr_reg.sv
// Two-deep write shift register (lo newest, hi previous) with two registered
// read ports: dout1 = {hi, lo}, dout2 = lo. Reads see pre-edge contents.
module idr_reg
    import idr_reg_pkg::*;
#(
    parameter int DW = IDR_DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            write,
    input  logic            read1,
    input  logic            read2,
    input  logic [DW-1:0]   din,
    output logic [2*DW-1:0] dout1,
    output logic [DW-1:0]   dout2
);

    logic [DW-1:0]       lo_reg;
    logic [DW-1:0]       hi_reg;
    logic [1:0][DW-1:0]  pair;

    // Index 1 is the upper half of dout1, so the halves line up with {hi, lo}.
    assign pair = {hi_reg, lo_reg};

    idr_word #(.W(DW)) u_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (write),
        .d     (din),
        .q     (lo_reg)
    );

    idr_word #(.W(DW)) u_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (write),
        .d     (lo_reg),
        .q     (hi_reg)
    );

    idr_word #(.W(DW)) u_dout2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (read2),
        .d     (lo_reg),
        .q     (dout2)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dout1
            idr_word #(.W(DW)) u_half (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (read1),
                .d     (pair[gi]),
                .q     (dout1[gi*DW +: DW])
            );
        end
    endgenerate

endmodule

// File: tb/tb_idr_reg.sv
// Directed bench for idr_reg: a reference model pushes expected read data to
// per-port queues when a read is driven; results are popped after the edge.
module tb_idr_reg;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0;
    logic        read1 = 1'b0;
    logic        read2 = 1'b0;
    logic [8:0]  din   = '0;
    logic [17:0] dout1;
    logic [8:0]  dout2;

    int tests = 0;
    int fails = 0;

    logic [8:0]  m_lo = '0;
    logic [8:0]  m_hi = '0;
    logic [17:0] m_d1 = '0;
    logic [8:0]  m_d2 = '0;
    logic [17:0] q1[$];
    logic [8:0]  q2[$];

    idr_reg #(.DW(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .write (write),
        .read1 (read1),
        .read2 (read2),
        .din   (din),
        .dout1 (dout1),
        .dout2 (dout2)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic [17:0] exp);
        tests++;
        assert (dout1 === exp) else begin
            fails++;
            $error("FAIL %s: dout1=%h expected %h", tag, dout1, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [8:0] exp);
        tests++;
        assert (dout2 === exp) else begin
            fails++;
            $error("FAIL %s: dout2=%h expected %h", tag, dout2, exp);
        end
    endtask

    // One clock of stimulus; every step checks both ports (hold when not read).
    task automatic step(input string tag, input bit w, input bit r1, input bit r2,
                        input logic [8:0] d);
        @(negedge clk);
        write = w; read1 = r1; read2 = r2; din = d;
        if (r1) q1.push_back({m_hi, m_lo});
        if (r2) q2.push_back(m_lo);
        if (w) begin
            m_hi = m_lo;
            m_lo = d;
        end
        @(posedge clk);
        #1;
        write = 1'b0; read1 = 1'b0; read2 = 1'b0;
        if (r1) begin
            tests++;
            assert (q1.size() != 0) else begin
                fails++;
                $error("FAIL %s: dout1 queue empty=%0d expected 0", tag, 1);
            end
            if (q1.size() != 0) m_d1 = q1.pop_front();
        end
        if (r2) begin
            tests++;
            assert (q2.size() != 0) else begin
                fails++;
                $error("FAIL %s: dout2 queue empty=%0d expected 0", tag, 1);
            end
            if (q2.size() != 0) m_d2 = q2.pop_front();
        end
        chk1(tag, m_d1);
        chk2(tag, m_d2);
        $display("[TB] %s w=%0b r1=%0b r2=%0b din=%h dout1=%h dout2=%h",
                 tag, w, r1, r2, d, dout1, dout2);
    endtask

    // Mid-cycle async reset with strobes active across an edge while held.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1({tag, "_async"}, 18'h0);
        chk2({tag, "_async"}, 9'h0);
        write = 1'b1; read1 = 1'b1; read2 = 1'b1; din = 9'h1FF;
        @(posedge clk);
        #1;
        chk1({tag, "_held"}, 18'h0);
        chk2({tag, "_held"}, 9'h0);
        @(negedge clk);
        write = 1'b0; read1 = 1'b0; read2 = 1'b0; din = '0;
        rst_n = 1'b1;
        m_lo = '0; m_hi = '0; m_d1 = '0; m_d2 = '0;
        q1.delete();
        q2.delete();
        $display("[TB] %s reset dout1=%h dout2=%h", tag, dout1, dout2);
    endtask

    initial begin
        #1;
        chk1("por", 18'h0);
        chk2("por", 9'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Same-edge write and read returns the old contents.
        step("wr_rd_same", 1, 1, 0, 9'h01A);
        chk1("wr_rd_same_const", 18'h00000);
        step("rd_after_wr", 0, 1, 0, 9'h000);
        chk1("rd_after_wr_const", 18'h0001A);

        do_reset("rst1");
        step("wr_01a", 1, 0, 0, 9'h01A);
        step("wr_101", 1, 0, 0, 9'h101);
        step("rd_both", 0, 1, 1, 9'h000);
        chk1("pair_const", 18'h03501);
        chk2("lo_const", 9'h101);

        step("wr_01b", 1, 0, 0, 9'h01B);
        step("rd_shift", 0, 1, 0, 9'h000);
        chk1("shift_const", 18'h2021B);

        for (int i = 0; i < 3; i++) begin
            step("idle", 0, 0, 0, (i % 2 == 0) ? 9'h1FF : 9'h000);
        end
        step("rd_idle", 0, 1, 1, 9'h155);
        chk1("idle_const", 18'h2021B);
        chk2("idle_lo_const", 9'h01B);

        // Held strobes: back-to-back shifts with reads every edge.
        for (int i = 0; i < 8; i++) begin
            step("b2b", 1, 1, 1, 9'($urandom_range(0, 511)));
        end
        step("b2b_rd", 0, 1, 1, 9'h000);

        step("wr_pre_rst", 1, 0, 0, 9'h055);
        do_reset("rst2");
        step("rd_post_rst", 0, 1, 1, 9'h000);
        chk1("post_rst_const", 18'h0);
        chk2("post_rst_lo_const", 9'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
